ex1_b: RTL and testbench

EX1_B -- requirements
Module: ex1_b

---
 rtl/ex1_b_pkg.sv | 21 ++
 rtl/ex1_b_mux5.sv | 34 +++
 rtl/ex1_b.sv | 51 +++++
 tb/tb_ex1_b.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/ex1_b_pkg.sv
// Shared constants for the ex1_b select/mux block: default data width and
// the named select encodings used by the mux and its users.
package ex1_b_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 3;
  localparam int unsigned SEL_WIDTH      = 3;

  typedef logic [SEL_WIDTH-1:0] sel_t;

  // Named encodings for the four low candidates; any sel with MSB set routes Y.
  localparam sel_t SEL_U = 3'b000;
  localparam sel_t SEL_V = 3'b001;
  localparam sel_t SEL_W = 3'b010;
  localparam sel_t SEL_X = 3'b011;

  // True when the select code routes the Y candidate.
  function automatic logic sel_is_y(input sel_t sel);
    return sel[SEL_WIDTH-1];
  endfunction

endpackage

// File: rtl/ex1_b_mux5.sv
// Combinational 5-way data selector. Codes 000..011 pick U..X, any code with
// the MSB set picks Y, and an unresolved select (X/Z) forces a zero result so
// unknowns never reach downstream state.
module ex1_b_mux5
  import ex1_b_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  sel_t                  sel,
  input  logic [DATA_WIDTH-1:0] u,
  input  logic [DATA_WIDTH-1:0] v,
  input  logic [DATA_WIDTH-1:0] w,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] y,
  output logic [DATA_WIDTH-1:0] m
);

  // Exact-match decode; the default arm catches unresolved select bits.
  always_comb begin
    m = '0;
    case (sel)
      SEL_U:   m = u;
      SEL_V:   m = v;
      SEL_W:   m = w;
      SEL_X:   m = x;
      sel_t'(3'b100),
      sel_t'(3'b101),
      sel_t'(3'b110),
      sel_t'(3'b111): m = y;
      default: m = '0;
    endcase
  end

endmodule

// File: rtl/ex1_b.sv
// ex1_b top: 5-way mux with a combinational result M, a registered copy M_q
// (one-cycle latency, async-cleared), and a Y-routed flag y_sel.
module ex1_b
  import ex1_b_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s2,
  input  logic                  s1,
  input  logic                  s0,
  input  logic [DATA_WIDTH-1:0] U,
  input  logic [DATA_WIDTH-1:0] V,
  input  logic [DATA_WIDTH-1:0] W,
  input  logic [DATA_WIDTH-1:0] X,
  input  logic [DATA_WIDTH-1:0] Y,
  output logic [DATA_WIDTH-1:0] M,
  output logic [DATA_WIDTH-1:0] M_q,
  output logic                  y_sel
);

  sel_t sel;

  assign sel = {s2, s1, s0};

  ex1_b_mux5 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mux5 (
    .sel (sel),
    .u   (U),
    .v   (V),
    .w   (W),
    .x   (X),
    .y   (Y),
    .m   (M)
  );

  // y_sel mirrors the select MSB combinationally; unaffected by reset.
  assign y_sel = sel_is_y(sel);

  // Registered copy of M; cleared at once by reset, first capture after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      M_q <= '0;
    end else begin
      M_q <= M;
    end
  end

endmodule

// File: tb/tb_ex1_b.sv
// Self-checking bench for ex1_b: directed vector table, random scoreboard
// vectors, and a hand-written async reset sequence.
module tb_ex1_b;

  localparam int unsigned DW   = 3;
  localparam int unsigned NVEC = 15;
  localparam int unsigned NRND = 16;

  logic          clk;
  logic          rst;
  logic          s2, s1, s0;
  logic [DW-1:0] U, V, W, X, Y;
  logic [DW-1:0] M, M_q;
  logic          y_sel;

  int total;
  int bad;

  typedef struct {
    logic [2:0]    sel;
    logic [DW-1:0] u, v, w, x, y;
    logic [DW-1:0] m;
    logic          ysel;
  } vec_t;

  vec_t tbl [NVEC];

  ex1_b #(
    .DATA_WIDTH (DW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .s2    (s2),
    .s1    (s1),
    .s0    (s0),
    .U     (U),
    .V     (V),
    .W     (W),
    .X     (X),
    .Y     (Y),
    .M     (M),
    .M_q   (M_q),
    .y_sel (y_sel)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] sel, input logic [DW-1:0] u,
                       input logic [DW-1:0] v, input logic [DW-1:0] w,
                       input logic [DW-1:0] x, input logic [DW-1:0] y);
    {s2, s1, s0} = sel;
    U = u; V = v; W = w; X = x; Y = y;
  endtask

  function automatic logic [DW-1:0] ref_mux(input logic [2:0] sel,
      input logic [DW-1:0] u, input logic [DW-1:0] v, input logic [DW-1:0] w,
      input logic [DW-1:0] x, input logic [DW-1:0] y);
    if (sel[2]) return y;
    if (sel == 3'b000) return u;
    if (sel == 3'b001) return v;
    if (sel == 3'b010) return w;
    return x;
  endfunction

  initial begin
    logic [2:0]    rsel;
    logic [DW-1:0] ru, rv, rw, rx, ry, rexp;

    total = 0;
    bad   = 0;

    //            sel     u  v  w  x  y   m  ysel
    tbl[0]  = '{3'b000, 0, 0, 0, 0, 0,  0, 1'b0};
    tbl[1]  = '{3'b001, 0, 0, 0, 0, 1,  0, 1'b0};
    tbl[2]  = '{3'b011, 0, 0, 0, 1, 1,  1, 1'b0};
    tbl[3]  = '{3'b010, 0, 0, 0, 1, 0,  0, 1'b0};
    tbl[4]  = '{3'b100, 0, 0, 1, 1, 0,  0, 1'b1};
    tbl[5]  = '{3'b101, 0, 0, 1, 1, 0,  0, 1'b1};
    tbl[6]  = '{3'b110, 0, 0, 1, 1, 0,  0, 1'b1};
    tbl[7]  = '{3'b111, 0, 0, 1, 1, 0,  0, 1'b1};
    tbl[8]  = '{3'b100, 0, 0, 1, 1, 7,  7, 1'b1};
    tbl[9]  = '{3'b101, 0, 0, 1, 1, 7,  7, 1'b1};
    tbl[10] = '{3'b110, 0, 0, 1, 1, 7,  7, 1'b1};
    tbl[11] = '{3'b111, 0, 0, 1, 1, 7,  7, 1'b1};
    tbl[12] = '{3'b000, 5, 2, 3, 4, 6,  5, 1'b0};
    tbl[13] = '{3'b001, 1, 6, 3, 4, 2,  6, 1'b0};
    tbl[14] = '{3'b010, 1, 2, 3, 4, 7,  3, 1'b0};

    rst = 1'b1;
    drive(3'b000, 0, 0, 0, 0, 0);
    #1;
    check("reset_mq", int'(M_q), 0);
    @(posedge clk); #1;
    check("reset_hold_mq", int'(M_q), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table: M and y_sel 5 ns after change, M_q one edge later.
    for (int i = 0; i < int'(NVEC); i++) begin
      @(negedge clk);
      drive(tbl[i].sel, tbl[i].u, tbl[i].v, tbl[i].w, tbl[i].x, tbl[i].y);
      #5;
      check($sformatf("vec%0d_m", i), int'(M), int'(tbl[i].m));
      check($sformatf("vec%0d_ysel", i), int'(y_sel), int'(tbl[i].ysel));
      @(posedge clk); #1;
      check($sformatf("vec%0d_mq", i), int'(M_q), int'(tbl[i].m));
    end

    // Random scoreboard vectors.
    for (int i = 0; i < int'(NRND); i++) begin
      rsel = 3'($urandom_range(0, 7));
      ru = DW'($urandom); rv = DW'($urandom); rw = DW'($urandom);
      rx = DW'($urandom); ry = DW'($urandom);
      rexp = ref_mux(rsel, ru, rv, rw, rx, ry);
      @(negedge clk);
      drive(rsel, ru, rv, rw, rx, ry);
      #5;
      check($sformatf("rnd%0d_m", i), int'(M), int'(rexp));
      check($sformatf("rnd%0d_ysel", i), int'(y_sel), int'(rsel[2]));
      @(posedge clk); #1;
      check($sformatf("rnd%0d_mq", i), int'(M_q), int'(rexp));
    end

    // Mid-run async reset with M=101: M_q clears at once, M untouched.
    @(negedge clk);
    drive(3'b101, 1, 2, 3, 4, 5);
    @(posedge clk); #1;
    check("pre_rst_mq", int'(M_q), 5);
    #4;
    rst = 1'b1;
    #1;
    check("rst_async_mq", int'(M_q), 0);
    check("rst_m_kept", int'(M), 5);
    check("rst_ysel_kept", int'(y_sel), 1);
    @(posedge clk); #1;
    check("rst_hold_mq", int'(M_q), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_release_mq", int'(M_q), 0);
    @(posedge clk); #1;
    check("post_rst_mq", int'(M_q), 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
